ram_in_loader: RTL and testbench

RAM_IN_LOADER -- requirements
Module: ram_in_loader

---
 rtl/ram_in_loader_pkg.sv | 12 +
 rtl/ram_in_loader_edge_detect_rise.sv | 16 +
 rtl/ram_in_loader.sv | 77 +++++++
 tb/tb_ram_in_loader.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ram_in_loader_pkg.sv
// rtl/ram_in_loader_pkg.sv - shared frame geometry and loader state encoding
package ram_in_loader_pkg;
  localparam int DEPTH_IN = 32;
  localparam int WIDTH_WR = 8;
  localparam int ADDR_W   = 5;

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/ram_in_loader_edge_detect_rise.sv
// rtl/ram_in_loader_edge_detect_rise.sv - one-cycle pulse on a rising level
module edge_detect_rise (
  input  logic clk,
  input  logic rset,
  input  logic d,
  output logic rise
);
  logic d_q;

  always_ff @(posedge clk) begin
    if (rset) d_q <= 1'b0;
    else      d_q <= d;
  end

  assign rise = d & ~d_q;
endmodule

// File: rtl/ram_in_loader.sv
// rtl/ram_in_loader.sv - fills the input RAM with one frame, then hands off to the transfer FSM
module ram_in_loader #(
  parameter int DEPTH_IN = ram_in_loader_pkg::DEPTH_IN,
  parameter int WIDTH_WR = ram_in_loader_pkg::WIDTH_WR
) (
  input  logic                                  clk,
  input  logic                                  rset,
  input  logic                                  s_valid,
  input  logic [WIDTH_WR-1:0]                   s_data,
  output logic                                  s_ready,
  output logic                                  ram_in_we,
  output logic [ram_in_loader_pkg::ADDR_W-1:0]  ram_in_addr_wr,
  output logic [WIDTH_WR-1:0]                   ram_in_data_wr,
  output logic                                  opmode_out,
  input  logic                                  done_in,
  output logic                                  busy,
  output logic [7:0]                            frame_cnt
);
  import ram_in_loader_pkg::*;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx;
  logic              accept, last_byte, done_rise, opmode_nxt;

  edge_detect_rise u_done_edge (
    .clk  (clk),
    .rset (rset),
    .d    (done_in),
    .rise (done_rise)
  );

  assign accept    = s_valid && s_ready;
  assign last_byte = (idx == ADDR_W'(DEPTH_IN - 1));

  always_ff @(posedge clk) begin
    if (rset) state <= FILL;
    else      state <= state_nxt;
  end

  // A rise coinciding with the opmode pulse cannot be a response to it, so it is ignored.
  always_comb begin
    state_nxt = state;
    unique case (state)
      FILL:      if (accept && last_byte) state_nxt = START;
      START:     state_nxt = WAIT_DONE;
      WAIT_DONE: if (done_rise && !opmode_out) state_nxt = FILL;
      default:   state_nxt = FILL;
    endcase
  end

  always_comb begin
    s_ready    = (state == FILL) && !rset;
    busy       = (state != FILL);
    opmode_nxt = (state == START);
  end

  always_ff @(posedge clk) begin
    if (rset) begin
      idx            <= '0;
      ram_in_we      <= 1'b0;
      ram_in_addr_wr <= '0;
      ram_in_data_wr <= '0;
      opmode_out     <= 1'b0;
      frame_cnt      <= 8'd0;
    end else begin
      ram_in_we  <= accept;
      opmode_out <= opmode_nxt;
      if (accept) begin
        ram_in_addr_wr <= idx;
        ram_in_data_wr <= s_data;
        idx            <= last_byte ? '0 : idx + ADDR_W'(1);
      end
      if (state == WAIT_DONE && state_nxt == FILL)
        frame_cnt <= frame_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_ram_in_loader.sv
// tb/tb_ram_in_loader.sv - directed table-driven bench for ram_in_loader
module tb_ram_in_loader;
  logic       clk = 1'b0;
  logic       rset = 1'b1;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       done_in = 1'b0;
  logic       s_ready, ram_in_we, opmode_out, busy;
  logic [4:0] ram_in_addr_wr;
  logic [7:0] ram_in_data_wr, frame_cnt;

  always #5 clk = ~clk;

  ram_in_loader dut (
    .clk            (clk),
    .rset           (rset),
    .s_valid        (s_valid),
    .s_data         (s_data),
    .s_ready        (s_ready),
    .ram_in_we      (ram_in_we),
    .ram_in_addr_wr (ram_in_addr_wr),
    .ram_in_data_wr (ram_in_data_wr),
    .opmode_out     (opmode_out),
    .done_in        (done_in),
    .busy           (busy),
    .frame_cnt      (frame_cnt)
  );

  typedef struct {
    logic [7:0] base;
    bit         gap;
    bit         hold;
    logic [7:0] exp_cnt;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0, wr_n = 0, op_cnt = 0, op_cyc = 0, we_bad = 0, rdy_bad = 0;
  logic acc_prev = 1'b0;
  logic [4:0] wr_addr [0:16383];
  logic [7:0] wr_data [0:16383];
  int         wr_cyc  [0:16383];

  // Write/pulse recorder: a write must appear exactly in the cycle after an acceptance.
  always @(negedge clk) begin
    if (ram_in_we !== acc_prev) we_bad++;
    if (ram_in_we === 1'b1 && wr_n < 16384) begin
      wr_addr[wr_n] = ram_in_addr_wr;
      wr_data[wr_n] = ram_in_data_wr;
      wr_cyc[wr_n]  = cyc;
      wr_n++;
    end
    if (opmode_out === 1'b1) begin
      op_cnt++;
      op_cyc = cyc;
    end
    if (busy === 1'b1 && s_ready !== 1'b0) rdy_bad++;
    acc_prev = s_valid & s_ready;
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [7:0] base, input bit gap, input bit hold,
                           input logic [7:0] exp_cnt);
    int w0, o0, g, bad;
    w0 = wr_n;
    o0 = op_cnt;
    if (hold) done_in = 1'b1;
    for (int i = 0; i < 32; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(base + i);
      g = 0;
      while (s_ready !== 1'b1 && g < 20) begin tick(); g++; end
      if (g >= 20) chk("s_ready_timeout", 32'(s_ready), 1);
      tick();
      if (gap) begin s_valid = 1'b0; tick(); end
    end
    s_valid = 1'b1;
    s_data  = 8'hEE;
    g = 0;
    while (opmode_out !== 1'b1 && g < 10) begin tick(); g++; end
    chk("opmode_seen", 32'(opmode_out), 1);
    if (hold) begin
      repeat (4) tick();
      chk("hold_stays_waiting", {busy, frame_cnt}, {1'b1, 8'(exp_cnt - 8'd1)});
      done_in = 1'b0;
      repeat (2) tick();
      done_in = 1'b1;
    end else begin
      repeat (3) tick();
      done_in = 1'b1;
    end
    g = 0;
    while (busy !== 1'b0 && g < 10) begin tick(); g++; end
    chk("frame_cnt", {busy, frame_cnt}, {1'b0, exp_cnt});
    s_valid = 1'b0;
    done_in = 1'b0;
    chk("write_count", wr_n - w0, 32);
    bad = 0;
    for (int k = 0; k < 32; k++)
      if (wr_addr[w0+k] !== 5'(k) || wr_data[w0+k] !== 8'(base + k)) bad++;
    chk("write_content", bad, 0);
    chk("write_span", wr_cyc[w0+31] - wr_cyc[w0], gap ? 62 : 31);
    chk("opmode_count", op_cnt - o0, 1);
    chk("opmode_timing", op_cyc - wr_cyc[w0+31], 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs [4];
    int w0, o0;
    vecs[0] = '{base: 8'h00, gap: 1'b0, hold: 1'b0, exp_cnt: 8'd1};
    vecs[1] = '{base: 8'h40, gap: 1'b1, hold: 1'b0, exp_cnt: 8'd2};
    vecs[2] = '{base: 8'h80, gap: 1'b0, hold: 1'b1, exp_cnt: 8'd3};
    vecs[3] = '{base: 8'hC0, gap: 1'b1, hold: 1'b1, exp_cnt: 8'd4};

    rset = 1'b1;
    repeat (3) tick();
    chk("reset_flags", {s_ready, ram_in_we, opmode_out, busy}, 0);
    chk("reset_frame_cnt", frame_cnt, 0);
    chk("reset_addr_data", {ram_in_addr_wr, ram_in_data_wr}, 0);
    rset = 1'b0;
    #1;
    chk("s_ready_after_reset", 32'(s_ready), 1);
    tick();

    for (int v = 0; v < 4; v++)
      run_frame(vecs[v].base, vecs[v].gap, vecs[v].hold, vecs[v].exp_cnt);

    w0 = wr_n;
    o0 = op_cnt;
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(8'h30 + i);
      tick();
    end
    s_valid = 1'b0;
    rset = 1'b1;
    repeat (2) tick();
    rset = 1'b0;
    repeat (5) tick();
    chk("partial_writes", wr_n - w0, 10);
    chk("no_opmode_after_reset", op_cnt - o0, 0);
    chk("frame_cnt_cleared", frame_cnt, 0);
    s_valid = 1'b1;
    s_data  = 8'h5A;
    tick();
    s_valid = 1'b0;
    chk("restart_write", {ram_in_we, ram_in_addr_wr, ram_in_data_wr, frame_cnt},
        {1'b1, 5'd0, 8'h5A, 8'd0});

    rset = 1'b1;
    tick();
    rset = 1'b0;
    tick();
    for (int k = 0; k < 256; k++)
      run_frame(8'(k), 1'b0, 1'b0, 8'(k + 1));

    chk("we_only_after_accept", we_bad, 0);
    chk("ready_low_when_busy", rdy_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
